// File: rtl/conv_pkg.sv
// Shared types for the conv_top memory read path.
// Address/data widths, requester ids and the read tag record.
package conv_pkg;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 256;
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [ADDR_W-1:0] mem_addr_t;
  typedef logic [ID_W-1:0]   req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    last;
  } rd_tag_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read tag delay line, one stage per cycle of memory latency.
// Exposes the oldest tag plus an any-valid flag for busy.
module rd_tag_pipe
  import conv_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o,
  output logic    any_valid
);

  rd_tag_t pipe_q [DEPTH];
  rd_tag_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | pipe_q[i].valid;
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_rd_arbiter.sv
// Round-robin burst arbiter for the single hb_mem read port.
// Issues one address per cycle and steers returning beats by tag.
module mem_rd_arbiter
  import conv_pkg::*;
#(
  parameter int NUM_REQ = conv_pkg::NUM_REQ,
  parameter int ADDR_W  = conv_pkg::ADDR_W,
  parameter int DATA_W  = conv_pkg::DATA_W,
  parameter int LEN_W   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                    rsp_last,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                    busy,
  output logic [ADDR_W-1:0]        r_addr,
  input  logic [DATA_W-1:0]        r_data
);

  arb_state_e        state_q, state_d;
  req_id_t           rr_q, rr_d;
  req_id_t           cur_q, cur_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  logic    found;
  req_id_t win;
  int      idx;
  logic    last_beat;
  logic    grant;

  rd_tag_t tag_in, tag_out;
  logic    tag_busy;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = req_id_t'(idx);
      end
    end
  end

  assign last_beat = (state_q == BURST) && (cnt_q == '0);
  assign grant = found &&
                 ((state_q == IDLE) || last_beat);

  // Gated by rst_n so no acceptance is seen while held in reset
  always_comb begin
    gnt = '0;
    if (grant && rst_n) begin
      gnt[win] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cur_d   = cur_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    if (state_q == BURST && !last_beat) begin
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
    end
    if (last_beat) begin
      state_d = IDLE;
    end
    if (grant) begin
      state_d = BURST;
      addr_d  = req_addr[int'(win)*ADDR_W +: ADDR_W];
      cnt_d   = req_len[int'(win)*LEN_W +: LEN_W];
      cur_d   = win;
      if (int'(win) == NUM_REQ - 1) begin
        rr_d = '0;
      end else begin
        rr_d = win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      cur_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cur_q   <= cur_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = (state_q == BURST);
    tag_in.id    = cur_q;
    tag_in.last  = last_beat;
  end

  rd_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_i     (tag_in),
    .tag_o     (tag_out),
    .any_valid (tag_busy)
  );

  always_comb begin
    rsp_valid = '0;
    if (tag_out.valid) begin
      rsp_valid[tag_out.id] = 1'b1;
    end
  end

  assign rsp_last = tag_out.valid & tag_out.last;
  assign rsp_data = r_data;
  assign busy     = (state_q == BURST) | tag_busy;
  assign r_addr   = addr_q;

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
Shares the single hb_mem read port (r_addr/r_data, fixed read latency) between NUM_REQ burst requesters inside conv_top, for example feature-map fetch and weight fetch.
- Grants one burst at a time using round-robin arbitration.
- Generates consecutive read addresses, one beat per cycle.
- Routes each returning 256-bit beat to the requester that issued it, using a tag pipeline matched to memory latency.

Parameters:
NUM_REQ, 2, number of requesters
ADDR_W, 20, memory word address width
DATA_W, 256, memory read data width
LEN_W, 4, burst length field width; a burst is len+1 beats (1..16)
MEM_LAT, 1, cycles from r_addr to valid r_data (must be >= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester burst request; held high until granted
req_addr  in  NUM_REQ*ADDR_W  per-requester burst base address
req_len  in  NUM_REQ*LEN_W  per-requester beats minus one
gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse
rsp_valid  out  NUM_REQ  one-hot, beat valid for that requester
rsp_last  out  1  final beat of the burst currently on rsp_data
rsp_data  out  DATA_W  returned beat (r_data passthrough)
busy  out  1  burst issuing or beats in flight
r_addr  out  ADDR_W  memory read address, registered
r_data  in  DATA_W  memory read data

Behaviour:
- Reset values (async, rst_n low): r_addr=0, gnt=0, rsp_valid=0, rsp_last=0, busy=0, state=IDLE, rr_ptr=0, beat counter=0, tag pipeline cleared.
- The state machine has two states, IDLE and BURST.
- Arbitration is combinational and takes effect in any cycle where state=IDLE, or state=BURST on the last beat.
  - Winner: the first asserted req[i] scanning from rr_ptr upward, modulo NUM_REQ.
  - gnt[winner]=1 in that same cycle.
  - At the clock edge: latch req_addr[winner] and req_len[winner], set cur_id=winner, rr_ptr=winner+1 mod NUM_REQ, state=BURST.
- Issue timing: a grant in cycle c gives r_addr=base in cycle c+1 and base+k in cycle c+1+k, for k=0..len. The address increment wraps modulo 2^ADDR_W.
- Back-to-back bursts: a grant on the last-beat cycle starts the next burst in the following cycle with zero bubble cycles.
- If no req is asserted on the last beat, the FSM goes to IDLE and r_addr holds its last value.
- Requester contract:
  - req_addr and req_len are sampled only in the gnt cycle.
  - The requester deasserts req, or presents its next burst, in the cycle after gnt.
  - Changing the inputs before gnt is legal.
- Tag pipeline: depth MEM_LAT, with fields {valid, id, last}, shifted every cycle.
  - A beat issued on r_addr in cycle k yields rsp_valid[id]=1 in cycle k+MEM_LAT.
  - In that cycle rsp_last equals the last flag of the beat and rsp_data=r_data.
- No backpressure: requesters must accept every beat.
- busy = (state==BURST) OR any valid tag in the pipeline.
- Reset mid-operation clears everything: the burst is aborted, in-flight beats are dropped, and no rsp_valid is asserted after reset is released.
- Only one requester can hold the port at a time, so gnt and rsp_valid are each at most one-hot.

Decomposition:
- Shared package conv_pkg holds:
  - the ADDR_W and DATA_W constants;
  - the typedef mem_addr_t (logic [ADDR_W-1:0]);
  - the typedef req_id_t (logic [$clog2(NUM_REQ)-1:0]);
  - the packed struct rd_tag_t {valid, id, last};
  - the state enum arb_state_e {IDLE, BURST}.
- One sub-module, rd_tag_pipe: a MEM_LAT-deep rd_tag_t shift register with async clear.

Test Plan:
- Single beat: req[0]=1 with addr 0x00100 and len 0 in cycle c → gnt[0] in c, r_addr=0x00100 in c+1, rsp_valid[0]=1 with rsp_last=1 and rsp_data=mem[0x00100] in c+2, busy=0 in c+3.
- Burst: req[1] with addr 0x00040 and len 3 → r_addr=0x40,0x41,0x42,0x43 on consecutive cycles; four rsp_valid[1] beats with data matching the memory image; rsp_last only on the fourth beat.
- Contention: req[0] and req[1] both held from reset, each with len 1 → grant order 0,1,0,1 and no bubble between bursts; r_addr stream continuous for 8 cycles.
- Wrap: addr 0xFFFFE with len 3 → r_addr=0xFFFFE,0xFFFFF,0x00000,0x00001.
- Reset mid-burst: len 15 burst, rst_n pulsed low at beat 5 → all outputs return to 0 immediately; no rsp_valid after release until a new gnt.
- Idle hold: no req after a burst ending at 0x00203 → r_addr stays 0x00203, gnt=0, busy falls MEM_LAT cycles after the last issue.
